// File: rtl/multiplier_nbyn_seq.sv
// Sequential unsigned shift-and-add multiplier: W x W -> 2W product, one
// partial-product step per clock, with the St/Ready handshake shared with the divider.
module multiplier_nbyn_seq #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           St,
  input  logic [W-1:0]   Multiplicand_in,
  input  logic [W-1:0]   Multiplier_in,
  output logic [2*W-1:0] Product,
  output logic           Ready,
  output logic           Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     mcand_reg;
  logic [2*W:0]     acc_reg;
  logic [2*W-1:0]   product_reg;
  logic             ready_reg;
  logic             done_reg;

  logic [W:0]       addend;
  logic [W:0]       sum;
  logic [2*W:0]     acc_next;

  // The W+1-bit adder keeps its carry in the top bit, so the shift never loses it.
  always_comb begin
    addend   = acc_reg[0] ? {1'b0, mcand_reg} : {(W+1){1'b0}};
    sum      = acc_reg[2*W:W] + addend;
    acc_next = {1'b0, sum, acc_reg[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (St) begin
            mcand_reg <= Multiplicand_in;
            acc_reg   <= {{(W+1){1'b0}}, Multiplier_in};
            cnt_reg   <= '0;
            state_reg <= RUN;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          if (cnt_reg == CNT_W'(W-1)) begin
            product_reg <= acc_next[2*W-1:0];
            cnt_reg     <= '0;
            state_reg   <= DONE;
            done_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign Product = product_reg;
  assign Ready   = ready_reg;
  assign Done    = done_reg;

endmodule
